// File: rtl/irq_pkg.sv
// Shared types for the interrupt preemption controller: context stack entry,
// pending-candidate record and FSM state encoding.
package irq_pkg;

  localparam int unsigned NrIrqLinesDef = 64;
  localparam int unsigned NrIrqPriosDef = 32;
  localparam int unsigned IrqIdW        = $clog2(NrIrqLinesDef);
  localparam int unsigned PrioW         = $clog2(NrIrqPriosDef);

  // Saved running context: priority level and whether it may be preempted.
  typedef struct packed {
    logic [PrioW-1:0] level;
    logic             nest;
  } ctx_t;

  // Candidate captured while a take request is outstanding.
  typedef struct packed {
    logic [IrqIdW-1:0] id;
    logic [PrioW-1:0]  level;
    logic              heti;
    logic              nest;
  } pend_t;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

endpackage

// File: rtl/irq_level_stack.sv
// LIFO of preempted contexts. Pushing while full and popping while empty
// are silently ignored; top_o reads 0 while empty.
module irq_level_stack
  import irq_pkg::*;
#(
  parameter  int unsigned Depth      = 4,
  localparam int unsigned DepthWidth = $clog2(Depth + 1),
  localparam int unsigned IdxWidth   = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  ctx_t                  push_data_i,
  input  logic                  pop_i,
  output ctx_t                  top_o,
  output logic [DepthWidth-1:0] depth_o,
  output logic                  full_o,
  output logic                  empty_o
);

  ctx_t                  mem_q [Depth];
  logic [DepthWidth-1:0] depth_q;
  logic [DepthWidth-1:0] depth_m1;
  logic [IdxWidth-1:0]   wr_idx;
  logic [IdxWidth-1:0]   rd_idx;

  assign depth_m1 = depth_q - DepthWidth'(1);
  assign wr_idx   = depth_q[IdxWidth-1:0];
  assign rd_idx   = depth_m1[IdxWidth-1:0];
  assign full_o   = (depth_q == DepthWidth'(Depth));
  assign empty_o  = (depth_q == '0);
  assign depth_o  = depth_q;
  assign top_o    = empty_o ? '0 : mem_q[rd_idx];

  // Storage and fill level; push wins only when there is room, pop only when non-empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      depth_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i && !full_o) begin
      mem_q[wr_idx] <= push_data_i;
      depth_q       <= depth_q + DepthWidth'(1);
    end else if (pop_i && !empty_o) begin
      depth_q <= depth_m1;
    end
  end

endmodule

// File: rtl/irq_preempt_ctrl.sv
// Core-side responder to the interrupt controller's claim handshake.
// Decides whether the arbitrated candidate may preempt the running context,
// raises a take request, and on core acceptance claims the line back.
//
//   state | meaning
//   RUN   | no take outstanding; latch an eligible candidate
//   PEND  | take_o raised; ack on take_ready, abort or re-latch otherwise
module irq_preempt_ctrl
  import irq_pkg::*;
#(
  parameter  int unsigned NrIrqLines = 64,
  parameter  int unsigned NrIrqPrios = 32,
  parameter  int unsigned StackDepth = 4,
  localparam int unsigned IrqWidth   = $clog2(NrIrqLines),
  localparam int unsigned PrioWidth  = $clog2(NrIrqPrios),
  localparam int unsigned DepthWidth = $clog2(StackDepth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  irq_valid_i,
  input  logic [IrqWidth-1:0]   irq_id_i,
  input  logic [PrioWidth-1:0]  irq_level_i,
  input  logic                  irq_heti_i,
  input  logic                  irq_nest_i,
  output logic                  irq_ack_o,
  output logic [IrqWidth-1:0]   irq_id_o,
  input  logic                  mie_i,
  input  logic                  take_ready_i,
  input  logic                  mret_i,
  output logic                  take_o,
  output logic [IrqWidth-1:0]   take_id_o,
  output logic                  take_heti_o,
  output logic [PrioWidth-1:0]  cur_level_o,
  output logic [DepthWidth-1:0] depth_o,
  output logic                  underflow_o
);

  // The shared record types are sized from the package defaults.
  if (IrqWidth != IrqIdW || PrioWidth != PrioW) begin : g_width_check
    $error("irq_preempt_ctrl: widths differ from irq_pkg record types");
  end

  state_t               state_q;
  pend_t                pend_q;
  pend_t                cand;
  logic [PrioWidth-1:0] cur_level_q;
  logic                 cur_nest_q;

  ctx_t                 push_ctx;
  ctx_t                 top_ctx;
  logic                 stk_full;
  logic                 stk_empty;
  logic                 elig;
  logic                 same_id;
  logic                 ack;
  logic                 pop;

  assign cand     = '{id: irq_id_i, level: irq_level_i, heti: irq_heti_i, nest: irq_nest_i};
  assign push_ctx = '{level: cur_level_q, nest: cur_nest_q};

  // Thread level (empty stack) is always preemptible; nested handlers only if marked nestable.
  assign elig = irq_valid_i & mie_i & (irq_level_i > cur_level_q)
              & (stk_empty | cur_nest_q) & ~stk_full;

  assign same_id = (irq_id_i == pend_q.id);
  assign ack     = (state_q == PEND) & ~mret_i & elig & same_id & take_ready_i;
  assign pop     = mret_i & ~stk_empty;

  assign irq_ack_o   = ack;
  assign irq_id_o    = ack ? pend_q.id : '0;
  assign take_o      = (state_q == PEND);
  assign take_id_o   = pend_q.id;
  assign take_heti_o = pend_q.heti;
  assign cur_level_o = cur_level_q;
  assign underflow_o = mret_i & stk_empty;

  irq_level_stack #(
    .Depth(StackDepth)
  ) u_stack (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (ack),
    .push_data_i(push_ctx),
    .pop_i      (pop),
    .top_o      (top_ctx),
    .depth_o    (depth_o),
    .full_o     (stk_full),
    .empty_o    (stk_empty)
  );

  // Take FSM plus running-context update; mret pop and ack push are mutually exclusive.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      pend_q      <= '0;
      cur_level_q <= '0;
      cur_nest_q  <= 1'b1;
    end else begin
      if (pop) begin
        cur_level_q <= top_ctx.level;
        cur_nest_q  <= top_ctx.nest;
      end else if (ack) begin
        cur_level_q <= pend_q.level;
        cur_nest_q  <= pend_q.nest;
      end

      case (state_q)
        RUN: begin
          if (elig && !mret_i) begin
            pend_q  <= cand;
            state_q <= PEND;
          end
        end
        PEND: begin
          if (mret_i || !elig) begin
            state_q <= RUN;
          end else if (!same_id) begin
            pend_q <= cand;
          end else if (take_ready_i) begin
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_preempt_ctrl.sv
// Directed bench for irq_preempt_ctrl: a per-cycle vector table followed by
// hand-written multi-cycle sequences.
module tb_irq_preempt_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       irq_valid;
  logic [5:0] irq_id;
  logic [4:0] irq_level;
  logic       irq_heti;
  logic       irq_nest;
  logic       irq_ack;
  logic [5:0] irq_id_out;
  logic       mie;
  logic       take_ready;
  logic       mret;
  logic       take;
  logic [5:0] take_id;
  logic       take_heti;
  logic [4:0] cur_level;
  logic [2:0] depth;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  irq_preempt_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .irq_valid_i (irq_valid),
    .irq_id_i    (irq_id),
    .irq_level_i (irq_level),
    .irq_heti_i  (irq_heti),
    .irq_nest_i  (irq_nest),
    .irq_ack_o   (irq_ack),
    .irq_id_o    (irq_id_out),
    .mie_i       (mie),
    .take_ready_i(take_ready),
    .mret_i      (mret),
    .take_o      (take),
    .take_id_o   (take_id),
    .take_heti_o (take_heti),
    .cur_level_o (cur_level),
    .depth_o     (depth),
    .underflow_o (underflow)
  );

  typedef struct {
    logic       v;
    logic [5:0] id;
    logic [4:0] lvl;
    logic       heti;
    logic       nest;
    logic       mie;
    logic       rdy;
    logic       mret;
    logic       e_take;
    logic [5:0] e_tid;
    logic       e_theti;
    logic       e_ack;
    logic [5:0] e_aid;
    logic [4:0] e_cur;
    logic [2:0] e_dep;
    logic       e_uf;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input logic v, input int id, input int lvl, input logic heti,
                              input logic nest, input logic m, input logic rdy, input logic mr,
                              input logic e_take, input int e_tid, input logic e_theti,
                              input logic e_ack, input int e_aid, input int e_cur,
                              input int e_dep, input logic e_uf);
    vec_t r;
    r.v = v; r.id = 6'(id); r.lvl = 5'(lvl); r.heti = heti; r.nest = nest;
    r.mie = m; r.rdy = rdy; r.mret = mr;
    r.e_take = e_take; r.e_tid = 6'(e_tid); r.e_theti = e_theti; r.e_ack = e_ack;
    r.e_aid = 6'(e_aid); r.e_cur = 5'(e_cur); r.e_dep = 3'(e_dep); r.e_uf = e_uf;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge and settle before sampling.
  task automatic cyc(input logic v, input int id, input int lvl, input logic heti,
                     input logic nest, input logic m, input logic rdy, input logic mr);
    @(negedge clk);
    irq_valid = v; irq_id = 6'(id); irq_level = 5'(lvl); irq_heti = heti;
    irq_nest = nest; mie = m; take_ready = rdy; mret = mr;
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    irq_valid = 0; irq_id = 0; irq_level = 0; irq_heti = 0; irq_nest = 0;
    mie = 0; take_ready = 0; mret = 0;

    //        v id lvl h n mie rdy mr | take tid th ack aid cur dep uf
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 5, 3, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 5, 3, 1, 1, 1, 1, 0,  1, 5, 1, 1, 5, 0, 0, 0);
    vecs[3]  = mk(0, 5, 3, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 3, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 3, 1, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 5, 3, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 5, 3, 0, 1, 1, 1, 0,  1, 5, 0, 1, 5, 0, 0, 0);
    vecs[8]  = mk(1, 6, 3, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 3, 1, 0);
    vecs[9]  = mk(1, 6, 3, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 3, 1, 0);
    vecs[10] = mk(1, 9, 7, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 3, 1, 0);
    vecs[11] = mk(1, 9, 7, 0, 1, 1, 0, 0,  1, 9, 0, 0, 0, 3, 1, 0);
    vecs[12] = mk(1, 9, 7, 0, 1, 1, 1, 0,  1, 9, 0, 1, 9, 3, 1, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 7, 2, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 7, 2, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 3, 1, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1);
    vecs[18] = mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[19] = mk(1, 7, 5, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[20] = mk(1, 7, 5, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[21] = mk(1, 7, 5, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[22] = mk(1, 7, 5, 0, 1, 0, 1, 0,  1, 7, 0, 0, 0, 0, 0, 0);
    vecs[23] = mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    #12;
    chk("rst.take", int'(take), 0);
    chk("rst.ack", int'(irq_ack), 0);
    chk("rst.cur_level", int'(cur_level), 0);
    chk("rst.depth", int'(depth), 0);
    chk("rst.underflow", int'(underflow), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: single take, equal level, preemption, underflow, mie gating
    for (int i = 0; i < 24; i++) begin
      cyc(vecs[i].v, int'(vecs[i].id), int'(vecs[i].lvl), vecs[i].heti, vecs[i].nest,
          vecs[i].mie, vecs[i].rdy, vecs[i].mret);
      chk($sformatf("v%0d.take", i), int'(take), int'(vecs[i].e_take));
      if (vecs[i].e_take) begin
        chk($sformatf("v%0d.take_id", i), int'(take_id), int'(vecs[i].e_tid));
        chk($sformatf("v%0d.take_heti", i), int'(take_heti), int'(vecs[i].e_theti));
      end
      chk($sformatf("v%0d.ack", i), int'(irq_ack), int'(vecs[i].e_ack));
      if (vecs[i].e_ack)
        chk($sformatf("v%0d.ack_id", i), int'(irq_id_out), int'(vecs[i].e_aid));
      chk($sformatf("v%0d.cur_level", i), int'(cur_level), int'(vecs[i].e_cur));
      chk($sformatf("v%0d.depth", i), int'(depth), int'(vecs[i].e_dep));
      chk($sformatf("v%0d.underflow", i), int'(underflow), int'(vecs[i].e_uf));
    end

    // Non-nestable running context blocks a higher level until mret
    cyc(1, 3, 3, 0, 0, 1, 1, 0);
    cyc(1, 3, 3, 0, 0, 1, 1, 0);
    chk("nn.ack", int'(irq_ack), 1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1, 4, 7, 0, 1, 1, 0, 0);
      if (take) seen++;
    end
    chk("nn.blocked_take_cycles", seen, 0);
    chk("nn.cur_level", int'(cur_level), 3);
    cyc(1, 4, 7, 0, 1, 1, 0, 1);
    cyc(1, 4, 7, 0, 1, 1, 0, 0);
    chk("nn.after_mret_depth", int'(depth), 0);
    cyc(1, 4, 7, 0, 1, 1, 0, 0);
    chk("nn.take", int'(take), 1);
    chk("nn.take_id", int'(take_id), 4);
    cyc(1, 4, 7, 0, 1, 1, 1, 0);
    chk("nn.ack2", int'(irq_ack), 1);
    chk("nn.ack2_id", int'(irq_id_out), 4);
    idle();
    chk("nn.cur_level2", int'(cur_level), 7);
    cyc(0, 0, 0, 0, 0, 1, 0, 1);
    idle();
    chk("nn.clean_depth", int'(depth), 0);

    // mret has priority over a ready take in PEND
    cyc(1, 10, 2, 0, 1, 1, 0, 0);
    cyc(1, 10, 2, 0, 1, 1, 1, 1);
    chk("mp.take", int'(take), 1);
    chk("mp.ack", int'(irq_ack), 0);
    chk("mp.underflow", int'(underflow), 1);
    idle();
    chk("mp.take_after", int'(take), 0);
    chk("mp.depth", int'(depth), 0);

    // Dropping valid in PEND aborts without ack
    cyc(1, 11, 4, 0, 1, 1, 0, 0);
    cyc(0, 11, 4, 0, 1, 1, 0, 0);
    chk("dv.take", int'(take), 1);
    chk("dv.ack", int'(irq_ack), 0);
    cyc(0, 11, 4, 0, 1, 1, 1, 0);
    chk("dv.take_after", int'(take), 0);
    chk("dv.ack_after", int'(irq_ack), 0);
    chk("dv.depth", int'(depth), 0);

    // Candidate switch in PEND re-latches, later ready acks the new id
    cyc(1, 11, 4, 0, 1, 1, 0, 0);
    cyc(1, 12, 8, 1, 1, 1, 0, 0);
    chk("rl.take_id_old", int'(take_id), 11);
    chk("rl.ack_old", int'(irq_ack), 0);
    cyc(1, 12, 8, 1, 1, 1, 0, 0);
    chk("rl.take", int'(take), 1);
    chk("rl.take_id_new", int'(take_id), 12);
    chk("rl.take_heti_new", int'(take_heti), 1);
    cyc(1, 12, 8, 1, 1, 1, 1, 0);
    chk("rl.ack", int'(irq_ack), 1);
    chk("rl.ack_id", int'(irq_id_out), 12);
    idle();
    chk("rl.cur_level", int'(cur_level), 8);
    chk("rl.depth", int'(depth), 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 1);
    idle();

    // Fill the stack with levels 1..4, then a higher candidate is refused
    for (int l = 1; l <= 4; l++) begin
      cyc(1, l, l, 0, 1, 1, 1, 0);
      cyc(1, l, l, 0, 1, 1, 1, 0);
      idle();
    end
    chk("sf.depth", int'(depth), 4);
    chk("sf.cur_level", int'(cur_level), 4);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1, 20, 9, 0, 1, 1, 1, 0);
      if (take || irq_ack) seen++;
    end
    chk("sf.full_takes", seen, 0);
    for (int k = 3; k >= 0; k--) begin
      cyc(0, 0, 0, 0, 0, 1, 0, 1);
      idle();
      chk($sformatf("sf.pop%0d.cur_level", k), int'(cur_level), k);
      chk($sformatf("sf.pop%0d.depth", k), int'(depth), k);
    end

    // Async reset in the middle of PEND clears outputs without a clock edge
    cyc(1, 2, 3, 0, 1, 1, 1, 0);
    cyc(1, 2, 3, 0, 1, 1, 1, 0);
    idle();
    cyc(1, 13, 6, 0, 1, 1, 0, 0);
    cyc(1, 13, 6, 0, 1, 1, 0, 0);
    take_ready = 1'b1;
    #1;
    chk("ar.pre_take", int'(take), 1);
    chk("ar.pre_ack", int'(irq_ack), 1);
    rst_n = 1'b0;
    #1;
    chk("ar.take", int'(take), 0);
    chk("ar.ack", int'(irq_ack), 0);
    chk("ar.cur_level", int'(cur_level), 0);
    chk("ar.depth", int'(depth), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
